// File: rtl/exec_ctrl.sv
// ----------------------------------------------------------------------------
// exec_ctrl -- multi-cycle sequencer for the RV32I core datapath.
//
// Holds the architectural PC and the instruction register. Each instruction is
// fetched over a valid/ready instruction bus, classified by an external
// combinational decoder, optionally stepped through the LSU, and retired in a
// single write-back cycle that gates both the register-file write and the PC
// update. Halt causes are latched (first cause wins) and cycle / retired
// instruction counters are maintained.
//
// Parameters:
//   ADDR_WIDTH  PC / bus address width
//   DATA_WIDTH  instruction and data width
//   RESET_PC    PC value loaded at reset
//   TIMEOUT     max cycles spent waiting in any bus state before halting (>=2)
//
// Ports:
//   clk, rst_n                   core clock, asynchronous active-low reset
//   ifu_req_valid/ready/addr     instruction fetch request (addr = pc)
//   ifu_rsp_valid/data/err       instruction fetch response
//   pc, inst                     current PC and instruction register to decoder
//   dec_*                        decoder classification and next PC
//   lsu_req_valid/ready          memory access request handshake
//   lsu_rsp_valid/err            memory access completion
//   rf_wen                       register-file write enable (WB only)
//   halted, halt_code            sticky halt flag and first halt cause
//   cycle_cnt, instret_cnt       cycle and retired-instruction counters
// ----------------------------------------------------------------------------
module exec_ctrl #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
    parameter int                    TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // instruction fetch bus
    output logic                  ifu_req_valid,
    input  logic                  ifu_req_ready,
    output logic [ADDR_WIDTH-1:0] ifu_req_addr,
    input  logic                  ifu_rsp_valid,
    input  logic [DATA_WIDTH-1:0] ifu_rsp_data,
    input  logic                  ifu_rsp_err,
    // decoder interface
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] inst,
    input  logic                  dec_is_load,
    input  logic                  dec_is_store,
    input  logic                  dec_regW,
    input  logic                  dec_ebreak,
    input  logic                  dec_inv,
    input  logic [ADDR_WIDTH-1:0] dec_dnpc,
    // load/store unit
    output logic                  lsu_req_valid,
    input  logic                  lsu_req_ready,
    input  logic                  lsu_rsp_valid,
    input  logic                  lsu_rsp_err,
    // status
    output logic                  rf_wen,
    output logic                  halted,
    output logic [1:0]            halt_code,
    output logic [31:0]           cycle_cnt,
    output logic [31:0]           instret_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        IF_REQ,
        IF_WAIT,
        EXEC,
        MEM_REQ,
        MEM_WAIT,
        WB,
        HALT
    } state_t;

    typedef enum logic [1:0] {
        HC_EBREAK  = 2'b00,
        HC_INVALID = 2'b01,
        HC_BUS_ERR = 2'b10,
        HC_TIMEOUT = 2'b11
    } halt_code_t;

    localparam logic [DATA_WIDTH-1:0] NOP_INST = 32'h0000_0013;
    localparam int                    WD_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]       WD_MAX   = WD_W'(TIMEOUT - 1);

    state_t          state, state_n;
    halt_code_t      halt_cause;
    logic [WD_W-1:0] wdog;
    logic            wd_expired;
    logic            in_bus_state;
    logic            inst_load;

    assign in_bus_state = (state == IF_REQ)  || (state == IF_WAIT) ||
                          (state == MEM_REQ) || (state == MEM_WAIT);
    assign wd_expired   = (wdog == WD_MAX);

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would infer a latch.
        state_n       = state;
        halt_cause    = HC_EBREAK;
        inst_load     = 1'b0;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        rf_wen        = 1'b0;

        case (state)
            IDLE: state_n = IF_REQ;

            IF_REQ: begin
                ifu_req_valid = 1'b1;
                if (ifu_req_ready) begin
                    state_n = IF_WAIT;
                end else if (wd_expired) begin
                    state_n    = HALT;
                    halt_cause = HC_TIMEOUT;
                end
            end

            IF_WAIT: begin
                if (ifu_rsp_valid) begin
                    if (ifu_rsp_err) begin
                        state_n    = HALT;
                        halt_cause = HC_BUS_ERR;
                    end else begin
                        state_n   = EXEC;
                        inst_load = 1'b1;
                    end
                end else if (wd_expired) begin
                    state_n    = HALT;
                    halt_cause = HC_TIMEOUT;
                end
            end

            EXEC: begin
                if (dec_ebreak) begin
                    state_n    = HALT;
                    halt_cause = HC_EBREAK;
                end else if (dec_inv) begin
                    state_n    = HALT;
                    halt_cause = HC_INVALID;
                end else if (dec_is_load || dec_is_store) begin
                    state_n = MEM_REQ;
                end else begin
                    state_n = WB;
                end
            end

            MEM_REQ: begin
                lsu_req_valid = 1'b1;
                if (lsu_req_ready) begin
                    state_n = MEM_WAIT;
                end else if (wd_expired) begin
                    state_n    = HALT;
                    halt_cause = HC_TIMEOUT;
                end
            end

            MEM_WAIT: begin
                if (lsu_rsp_valid) begin
                    if (lsu_rsp_err) begin
                        state_n    = HALT;
                        halt_cause = HC_BUS_ERR;
                    end else begin
                        state_n = WB;
                    end
                end else if (wd_expired) begin
                    state_n    = HALT;
                    halt_cause = HC_TIMEOUT;
                end
            end

            WB: begin
                // Stores may report regW from the decoder; they never write rd.
                rf_wen  = dec_regW & ~dec_is_store;
                state_n = IF_REQ;
            end

            HALT: state_n = HALT;

            default: state_n = IDLE;
        endcase
    end

    assign ifu_req_addr = pc;
    assign halted       = (state == HALT);

    // ------------------------------------------------------------------------
    // State, architectural registers, watchdog and counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inst        <= NOP_INST;
            wdog        <= '0;
            halt_code   <= HC_EBREAK;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= state_n;

            // Progress (any state change) rearms the watchdog; it only counts
            // while waiting on a bus and halts before it could wrap.
            if (state_n != state) begin
                wdog <= '0;
            end else if (in_bus_state) begin
                wdog <= wdog + 1'b1;
            end

            if (inst_load) begin
                inst <= ifu_rsp_data;
            end

            // Register file and PC commit on the same edge, so a jalr with
            // rd == rs1 computes dec_dnpc from the old rs1 value.
            if (state == WB) begin
                pc          <= dec_dnpc;
                instret_cnt <= instret_cnt + 32'd1;
            end

            // HALT is absorbing, so the first recorded cause is never replaced.
            if (state != HALT && state_n == HALT) begin
                halt_code <= halt_cause;
            end

            if (state != HALT) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
        end
    end

endmodule
